// File: rtl/arit_pkg.sv
// Shared definitions for the sequential arithmetic unit.
//   WIDTH_DEF  : default operand width
//   estado_t   : divider FSM state encoding
//   cnt_width  : iteration counter width for a given operand width
package arit_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } estado_t;

    // Counter must reach WIDTH, hence WIDTH+1 distinct values.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/division_paso.sv
// One restoring-division iteration (shift, compare, conditional subtract).
// Purely combinational.
//   i_r   : partial remainder before the step
//   i_q   : quotient/dividend shift register before the step
//   i_d   : divisor
//   o_r_c : partial remainder after the step
//   o_q_c : quotient shift register after the step (new bit in LSB)
module division_paso
    import arit_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_r_c,
    output logic [WIDTH-1:0] o_q_c
);

    logic [WIDTH:0] w_shift;
    logic           w_ge;

    // The shifted remainder needs WIDTH+1 bits; the result always fits back
    // into WIDTH bits because it ends up strictly below the divisor.
    always_comb begin
        w_shift = {i_r, i_q[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, i_d});
        o_r_c   = w_ge ? WIDTH'(w_shift - {1'b0, i_d}) : w_shift[WIDTH-1:0];
        o_q_c   = {i_q[WIDTH-2:0], w_ge};
    end

endmodule

// File: rtl/division_secuencial.sv
// Iterative unsigned restoring divider: one quotient bit per clock.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   a, b       : dividend / divisor, sampled only on the accepted start cycle
//   enable     : start request, honoured only in IDLE
//   cociente   : quotient, registered, held until the next result
//   residuo    : remainder, registered, held until the next result
//   ocupado    : high during the WIDTH iteration cycles
//   listo      : one-cycle pulse when cociente/residuo become valid
//   div_cero   : set with the results when the divisor was zero
module division_secuencial
    import arit_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             enable,
    output logic [WIDTH-1:0] cociente,
    output logic [WIDTH-1:0] residuo,
    output logic             ocupado,
    output logic             listo,
    output logic             div_cero
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    estado_t          r_state;
    estado_t          w_next;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] r_count;

    logic [WIDTH-1:0] r_cociente;
    logic [WIDTH-1:0] r_residuo;
    logic             r_ocupado;
    logic             r_listo;
    logic             r_div_cero;

    logic [WIDTH-1:0] w_q_c;
    logic [WIDTH-1:0] w_r_c;
    logic             w_b_cero;
    logic             w_last;

    assign w_b_cero = (b == '0);
    assign w_last   = (r_count == CNT_W'(WIDTH - 1));

    // Single iteration of the datapath.
    division_paso #(
        .WIDTH (WIDTH)
    ) u_paso (
        .i_r   (r_rem),
        .i_q   (r_q),
        .i_d   (r_d),
        .o_r_c (w_r_c),
        .o_q_c (w_q_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; divide-by-zero skips the iterations entirely.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_next = w_b_cero ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Iteration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_d     <= '0;
            r_rem   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable && !w_b_cero) begin
                        r_q     <= a;
                        r_d     <= b;
                        r_rem   <= '0;
                        r_count <= '0;
                    end
                end
                CALC: begin
                    r_q     <= w_q_c;
                    r_rem   <= w_r_c;
                    r_count <= r_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Result registers load on the edge entering DONE so they are valid
    // in the same cycle as the listo pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cociente <= '0;
            r_residuo  <= '0;
            r_div_cero <= 1'b0;
        end else begin
            if (r_state == IDLE && enable && w_b_cero) begin
                r_cociente <= '1;
                r_residuo  <= a;
                r_div_cero <= 1'b1;
            end else if (r_state == CALC && w_last) begin
                r_cociente <= w_q_c;
                r_residuo  <= w_r_c;
                r_div_cero <= 1'b0;
            end
        end
    end

    // Handshake flags track the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ocupado <= 1'b0;
            r_listo   <= 1'b0;
        end else begin
            r_ocupado <= (w_next == CALC);
            r_listo   <= (w_next == DONE);
        end
    end

    assign cociente = r_cociente;
    assign residuo  = r_residuo;
    assign ocupado  = r_ocupado;
    assign listo    = r_listo;
    assign div_cero = r_div_cero;

endmodule

// File: tb/tb_division_secuencial.sv
// Self-checking bench for division_secuencial (WIDTH=32).
module tb_division_secuencial;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         enable;
    logic [W-1:0] cociente;
    logic [W-1:0] residuo;
    logic         ocupado;
    logic         listo;
    logic         div_cero;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vecs[11];

    division_secuencial #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .enable   (enable),
        .cociente (cociente),
        .residuo  (residuo),
        .ocupado  (ocupado),
        .listo    (listo),
        .div_cero (div_cero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present operands for one cycle, then scramble them.
    task automatic start(input logic [W-1:0] va, input logic [W-1:0] vb);
        a      = va;
        b      = vb;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        a      = $urandom;
        b      = $urandom;
    endtask

    // Count cycles (sampled on negedge) until listo, with a bound.
    task automatic wait_listo(output int lat, output int busy);
        lat  = 0;
        busy = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (listo) break;
            if (ocupado) busy++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int busy;
        start(v.a, v.b);
        wait_listo(lat, busy);
        check({tag, "_latency"}, 64'(lat), v.dz ? 64'd1 : 64'(W + 1));
        check({tag, "_busy"}, 64'(busy), v.dz ? 64'd0 : 64'(W));
        check({tag, "_cociente"}, 64'(cociente), 64'(v.q));
        check({tag, "_residuo"}, 64'(residuo), 64'(v.r));
        check({tag, "_div_cero"}, 64'(div_cero), 64'(v.dz));
        @(negedge clk);
        check({tag, "_listo_pulse"}, 64'(listo), 64'd0);
    endtask

    initial begin
        int   lat;
        int   busy;
        logic bad;
        vec_t v;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        a        = '0;
        b        = '0;

        vecs[0]  = '{32'd128,        32'd16,         32'd8,          32'd0,  1'b0};
        vecs[1]  = '{32'd100,        32'd7,          32'd14,         32'd2,  1'b0};
        vecs[2]  = '{32'd4148,       32'd122,        32'd34,         32'd0,  1'b0};
        vecs[3]  = '{32'd55,         32'd0,          32'hFFFFFFFF,   32'd55, 1'b1};
        vecs[4]  = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,  1'b0};
        vecs[5]  = '{32'd5,          32'd9,          32'd0,          32'd5,  1'b0};
        vecs[6]  = '{32'd0,          32'd7,          32'd0,          32'd0,  1'b0};
        vecs[7]  = '{32'd1000,       32'd1000,       32'd1,          32'd0,  1'b0};
        vecs[8]  = '{32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          32'd1,  1'b0};
        vecs[9]  = '{32'h80000000,   32'd3,          32'd715827882,  32'd2,  1'b0};
        vecs[10] = '{32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,  1'b1};

        repeat (2) @(negedge clk);
        check("rst_cociente", 64'(cociente), 64'd0);
        check("rst_residuo", 64'(residuo), 64'd0);
        check("rst_ocupado", 64'(ocupado), 64'd0);
        check("rst_listo", 64'(listo), 64'd0);
        check("rst_div_cero", 64'(div_cero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Results hold while idle with enable low.
        repeat (10) @(negedge clk);
        check("hold_cociente", 64'(cociente), 64'hFFFFFFFF);
        check("hold_div_cero", 64'(div_cero), 64'd1);
        check("hold_ocupado", 64'(ocupado), 64'd0);

        // enable and operand changes during CALC are ignored.
        start(32'd1000, 32'd7);
        repeat (5) @(negedge clk);
        a      = 32'd9;
        b      = 32'd3;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        wait_listo(lat, busy);
        check("midcalc_latency", 64'(lat), 64'(W + 1 - 8));
        check("midcalc_busy", 64'(busy), 64'(W - 8));
        check("midcalc_cociente", 64'(cociente), 64'd142);
        check("midcalc_residuo", 64'(residuo), 64'd6);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ocupado || listo) bad = 1'b1;
        end
        check("midcalc_no_queue", 64'(bad), 64'd0);

        // enable held high re-arms in the first IDLE cycle after DONE.
        a      = 32'd50;
        b      = 32'd5;
        enable = 1'b1;
        @(posedge clk);
        wait_listo(lat, busy);
        check("rearm1_latency", 64'(lat), 64'(W + 1));
        check("rearm1_cociente", 64'(cociente), 64'd10);
        check("rearm1_residuo", 64'(residuo), 64'd0);
        a = 32'd9;
        b = 32'd3;
        @(negedge clk);
        check("rearm_idle_ocupado", 64'(ocupado), 64'd0);
        check("rearm_idle_listo", 64'(listo), 64'd0);
        @(posedge clk);
        #1;
        enable = 1'b0;
        wait_listo(lat, busy);
        check("rearm2_latency", 64'(lat), 64'(W + 1));
        check("rearm2_cociente", 64'(cociente), 64'd3);
        check("rearm2_residuo", 64'(residuo), 64'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of a division.
        start(32'd200, 32'd7);
        repeat (10) @(negedge clk);
        check("prerst_ocupado", 64'(ocupado), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_cociente", 64'(cociente), 64'd0);
        check("midrst_residuo", 64'(residuo), 64'd0);
        check("midrst_ocupado", 64'(ocupado), 64'd0);
        check("midrst_listo", 64'(listo), 64'd0);
        check("midrst_div_cero", 64'(div_cero), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad   = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (listo || ocupado) bad = 1'b1;
        end
        check("postrst_quiet", 64'(bad), 64'd0);

        v = '{32'd20, 32'd3, 32'd6, 32'd2, 1'b0};
        run_vec(v, "postrst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
